sim_memory_model_req_arbiter: RTL and testbench

Two-port request arbiter and response router in front of the simulation memory model's request queue. It merges two requesters (e.g. fetch and load/store) onto the single memory request stream, holds the grant across multi-beat bursts, and returns each response to the requester that issued the matching beat, in issue order. It sits between the core-side bus model and the memory model request/response path.

---
 rtl/sim_memory_model_arb_pkg.sv | 19 +
 rtl/sim_memory_model_req_arbiter_if.sv | 40 ++++
 rtl/sim_memory_model_arb_order_queue.sv | 72 +++++++
 rtl/sim_memory_model_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_sim_memory_model_req_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sim_memory_model_arb_pkg.sv
// Shared types and default widths for the simulation memory model request
// arbiter: FSM state encoding, requester port id, and default sizes.
package sim_memory_model_arb_pkg;

    localparam int ARB_N        = 64;
    localparam int ARB_RN       = 32;
    localparam int ARB_OQ_DEPTH = 16;
    localparam int ARB_OQ_D_N   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

    // 0 = port 0 (e.g. fetch), 1 = port 1 (e.g. load/store)
    typedef logic port_id_t;

endpackage

// File: rtl/sim_memory_model_req_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory model
// request/response path. The slave view belongs to the arbiter; the master
// view belongs to whatever drives the requesters and the memory model.
interface sim_memory_model_req_arbiter_if #(
    parameter int N  = 64,
    parameter int RN = 32
);
    logic          iP0_REQ;
    logic          iP1_REQ;
    logic          iP0_LAST;
    logic          iP1_LAST;
    logic [N-1:0]  iP0_DATA;
    logic [N-1:0]  iP1_DATA;
    logic          oP0_BUSY;
    logic          oP1_BUSY;
    logic          oP0_VALID;
    logic          oP1_VALID;
    logic [RN-1:0] oP0_DATA;
    logic [RN-1:0] oP1_DATA;
    logic          oMEM_REQ;
    logic [N-1:0]  oMEM_DATA;
    logic          iMEM_BUSY;
    logic          iMEM_VALID;
    logic [RN-1:0] iMEM_DATA;

    modport slave (
        input  iP0_REQ, iP1_REQ, iP0_LAST, iP1_LAST, iP0_DATA, iP1_DATA,
        output oP0_BUSY, oP1_BUSY, oP0_VALID, oP1_VALID, oP0_DATA, oP1_DATA,
        output oMEM_REQ, oMEM_DATA,
        input  iMEM_BUSY, iMEM_VALID, iMEM_DATA
    );

    modport master (
        output iP0_REQ, iP1_REQ, iP0_LAST, iP1_LAST, iP0_DATA, iP1_DATA,
        input  oP0_BUSY, oP1_BUSY, oP0_VALID, oP1_VALID, oP0_DATA, oP1_DATA,
        input  oMEM_REQ, oMEM_DATA,
        output iMEM_BUSY, iMEM_VALID, iMEM_DATA
    );

endinterface

// File: rtl/sim_memory_model_arb_order_queue.sv
// Order queue: 1-bit-wide synchronous FIFO recording which port issued each
// outstanding memory beat. Pointers carry one extra wrap bit so occupancy is
// simply write pointer minus read pointer. DEPTH must be a power of two.
module sim_memory_model_arb_order_queue
    import sim_memory_model_arb_pkg::*;
#(
    parameter int DEPTH = ARB_OQ_DEPTH,
    parameter int D_N   = ARB_OQ_D_N
)(
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic         iFLUSH,
    input  logic         iPUSH,
    input  port_id_t     iPUSH_ID,
    input  logic         iPOP,
    output port_id_t     oHEAD,
    output logic         oFULL,
    output logic         oEMPTY,
    output logic [D_N:0] oCOUNT
);

    localparam logic [D_N:0] PTR_ONE = (D_N+1)'(1);
    localparam logic [D_N:0] CAP     = (D_N+1)'(DEPTH);

    logic [D_N:0] wptr_q, wptr_d;
    logic [D_N:0] rptr_q, rptr_d;
    logic         wr_en;
    port_id_t     mem_q [DEPTH];

    assign oCOUNT = wptr_q - rptr_q;
    assign oFULL  = (oCOUNT == CAP);
    assign oEMPTY = (wptr_q == rptr_q);
    assign oHEAD  = mem_q[rptr_q[D_N-1:0]];

    // Pointer advance; a flush discards every entry at once.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        wr_en  = 1'b0;
        if (iFLUSH) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (iPUSH && !oFULL) begin
                wptr_d = wptr_q + PTR_ONE;
                wr_en  = 1'b1;
            end
            if (iPOP && !oEMPTY) begin
                rptr_d = rptr_q + PTR_ONE;
            end
        end
    end

    // Pointer registers with asynchronous clear.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Id storage; contents are meaningless until written, so no reset.
    always_ff @(posedge iCLOCK) begin
        if (wr_en) begin
            mem_q[wptr_q[D_N-1:0]] <= iPUSH_ID;
        end
    end

endmodule

// File: rtl/sim_memory_model_req_arbiter.sv
// Two-port request arbiter and response router for the simulation memory
// model. Grants one beat per cycle, holds the grant across a burst until its
// LAST beat, and routes each response to the port that issued the matching
// beat in issue order.
// Build option: SIM_MEMORY_MODEL_ARB_FIXED_PRIORITY_EN makes port 0 always win
// a contested IDLE cycle; otherwise a round-robin pointer alternates.
module sim_memory_model_req_arbiter
    import sim_memory_model_arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int RN       = ARB_RN,
    parameter int OQ_DEPTH = ARB_OQ_DEPTH,
    parameter int OQ_D_N   = ARB_OQ_D_N
)(
    input  logic                           iCLOCK,
    input  logic                           inRESET,
    input  logic                           iREMOVE,
    sim_memory_model_req_arbiter_if.slave  bus,
    output logic [OQ_D_N:0]                oOUTSTANDING,
    output logic                           oERR
);

    localparam logic [1:0] IDLE  = ARB_IDLE;
    localparam logic [1:0] LOCK0 = ARB_LOCK0;
    localparam logic [1:0] LOCK1 = ARB_LOCK1;

    logic [1:0]    state_q, state_d;
    logic          rr_q, rr_d;
    logic          err_q, err_d;

    logic          active;
    logic          can_push;
    logic          win_vld;
    port_id_t      win_id;
    logic          win_last;
    logic          accept;
    logic [N-1:0]  win_data;
    logic          rsp;
    logic          pop;
    logic [RN-1:0] rsp_data;

    logic          oq_full;
    logic          oq_empty;
    port_id_t      oq_head;

    sim_memory_model_arb_order_queue #(
        .DEPTH (OQ_DEPTH),
        .D_N   (OQ_D_N)
    ) u_order_queue (
        .iCLOCK   (iCLOCK),
        .inRESET  (inRESET),
        .iFLUSH   (iREMOVE),
        .iPUSH    (accept),
        .iPUSH_ID (win_id),
        .iPOP     (pop),
        .oHEAD    (oq_head),
        .oFULL    (oq_full),
        .oEMPTY   (oq_empty),
        .oCOUNT   (oOUTSTANDING)
    );

    assign oERR = err_q;

    // Pick the eligible winner: the locked port during a burst, else arbitrate.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 1'b0;
        case (state_q)
            LOCK0: begin
                win_vld = bus.iP0_REQ;
                win_id  = 1'b0;
            end
            LOCK1: begin
                win_vld = bus.iP1_REQ;
                win_id  = 1'b1;
            end
            default: begin
                win_vld = bus.iP0_REQ | bus.iP1_REQ;
                if (bus.iP0_REQ && bus.iP1_REQ) begin
`ifdef SIM_MEMORY_MODEL_ARB_FIXED_PRIORITY_EN
                    win_id = 1'b0;
`else
                    win_id = rr_q;
`endif
                end else begin
                    win_id = bus.iP1_REQ;
                end
            end
        endcase
    end

    // Accept and route combinationally; reset and flush block both paths.
    always_comb begin
        active   = inRESET && !iREMOVE;
        can_push = !bus.iMEM_BUSY && !oq_full;
        accept   = active && win_vld && can_push;
        win_last = win_id ? bus.iP1_LAST : bus.iP0_LAST;
        win_data = win_id ? bus.iP1_DATA : bus.iP0_DATA;
        rsp      = active && bus.iMEM_VALID;
        pop      = rsp && !oq_empty;
        rsp_data = bus.iMEM_DATA;

        bus.oMEM_REQ  = accept;
        bus.oMEM_DATA = accept ? win_data : '0;
        bus.oP0_BUSY  = !(accept && !win_id);
        bus.oP1_BUSY  = !(accept && win_id);
        bus.oP0_VALID = pop && !oq_head;
        bus.oP1_VALID = pop && oq_head;
        bus.oP0_DATA  = (pop && !oq_head) ? rsp_data : '0;
        bus.oP1_DATA  = (pop && oq_head)  ? rsp_data : '0;
    end

    // Next grant state, round-robin pointer and sticky error.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        err_d   = err_q;
        if (iREMOVE) begin
            state_d = IDLE;
            rr_d    = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (accept) begin
                if (win_last) begin
                    state_d = IDLE;
                    rr_d    = !win_id;
                end else begin
                    state_d = win_id ? LOCK1 : LOCK0;
                end
            end
            if (rsp && oq_empty) begin
                err_d = 1'b1;
            end
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sim_memory_model_req_arbiter.sv
// Randomized and directed bench for sim_memory_model_req_arbiter. Each driven
// cycle pushes the reference model's expected outputs into a queue; a monitor
// on the falling edge pops and compares against what the DUT presents.
module tb_sim_memory_model_req_arbiter;

`ifdef SIM_MEMORY_MODEL_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       inRESET;
    logic       iREMOVE;
    logic [4:0] oOUTSTANDING;
    logic       oERR;

    sim_memory_model_req_arbiter_if #(.N(64), .RN(32)) bus();

    sim_memory_model_req_arbiter dut (
        .iCLOCK       (clk),
        .inRESET      (inRESET),
        .iREMOVE      (iREMOVE),
        .bus          (bus),
        .oOUTSTANDING (oOUTSTANDING),
        .oERR         (oERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mreq;
        logic [63:0] mdata;
        bit          b0, b1, v0, v1;
        logic [31:0] d0, d1;
        int          outst;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: which port (if any) owns the grant, who is preferred
    // next, the list of ports whose beats are still awaiting a response.
    int   lock_m = -1;
    bit   pref_m = 1'b0;
    bit   ids_m[$];
    bit   err_m  = 1'b0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    task automatic step(input bit rn, input bit rm,
                        input bit r0, input bit l0, input logic [63:0] d0,
                        input bit r1, input bit l1, input logic [63:0] d1,
                        input bit mb, input bit mv, input logic [31:0] md);
        exp_t e;
        int   cand;
        bit   space;
        bit   port;
        bit   last;
        @(posedge clk);
        #1;
        inRESET        = rn;
        iREMOVE        = rm;
        bus.iP0_REQ    = r0;
        bus.iP0_LAST   = l0;
        bus.iP0_DATA   = d0;
        bus.iP1_REQ    = r1;
        bus.iP1_LAST   = l1;
        bus.iP1_DATA   = d1;
        bus.iMEM_BUSY  = mb;
        bus.iMEM_VALID = mv;
        bus.iMEM_DATA  = md;

        e = '{mreq: 1'b0, mdata: 64'd0, b0: 1'b1, b1: 1'b1, v0: 1'b0, v1: 1'b0,
              d0: 32'd0, d1: 32'd0, outst: ids_m.size(), err: err_m};
        if (!rn || rm) begin
            if (!rn) begin
                e.outst = 0;
                e.err   = 1'b0;
            end
            lock_m = -1;
            pref_m = 1'b0;
            ids_m.delete();
            err_m  = 1'b0;
        end else begin
            cand = -1;
            if (lock_m == 0)      cand = r0 ? 0 : -1;
            else if (lock_m == 1) cand = r1 ? 1 : -1;
            else if (r0 && r1)    cand = FIXED ? 0 : int'(pref_m);
            else if (r0)          cand = 0;
            else if (r1)          cand = 1;
            space = !mb && (ids_m.size() < DEPTH);
            if (mv) begin
                if (ids_m.size() > 0) begin
                    port = ids_m.pop_front();
                    if (port) begin e.v1 = 1'b1; e.d1 = md; end
                    else      begin e.v0 = 1'b1; e.d0 = md; end
                end else begin
                    err_m = 1'b1;
                end
            end
            if (cand >= 0 && space) begin
                e.mreq  = 1'b1;
                e.mdata = (cand == 1) ? d1 : d0;
                if (cand == 1) e.b1 = 1'b0;
                else           e.b0 = 1'b0;
                ids_m.push_back(cand == 1);
                last = (cand == 1) ? l1 : l0;
                if (last) begin
                    lock_m = -1;
                    pref_m = (cand == 0);
                end else begin
                    lock_m = cand;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (ids_m.size() > 0 && guard < 64) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom);
            guard++;
        end
    endtask

    // Monitor: compare every field the model predicted for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_req", 64'(bus.oMEM_REQ), 64'(e.mreq));
            if (e.mreq) chk("mem_data", bus.oMEM_DATA, e.mdata);
            chk("p0_busy", 64'(bus.oP0_BUSY), 64'(e.b0));
            chk("p1_busy", 64'(bus.oP1_BUSY), 64'(e.b1));
            chk("p0_valid", 64'(bus.oP0_VALID), 64'(e.v0));
            chk("p1_valid", 64'(bus.oP1_VALID), 64'(e.v1));
            if (e.v0 || e.v1) begin
                chk("p0_data", 64'(bus.oP0_DATA), 64'(e.d0));
                chk("p1_data", 64'(bus.oP1_DATA), 64'(e.d1));
            end
            chk("outstanding", 64'(oOUTSTANDING), 64'(e.outst));
            chk("err", 64'(oERR), 64'(e.err));
        end
    end

    initial begin
        bit rn, rm, r0, l0, r1, l1, mb, mv;
        inRESET = 1'b0; iREMOVE = 1'b0;
        bus.iP0_REQ = 1'b0; bus.iP0_LAST = 1'b0; bus.iP0_DATA = '0;
        bus.iP1_REQ = 1'b0; bus.iP1_LAST = 1'b0; bus.iP1_DATA = '0;
        bus.iMEM_BUSY = 1'b0; bus.iMEM_VALID = 1'b0; bus.iMEM_DATA = '0;

        // Reset held with requests and a response pending: outputs stay quiet.
        step(0, 0, 1, 1, 64'h77, 1, 1, 64'h88, 0, 1, 32'h5);
        step(0, 0, 1, 0, 64'h77, 1, 0, 64'h88, 0, 0, 32'h0);
        idle(1);

        // Single beat then its response.
        step(1, 0, 1, 1, 64'h11, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5);
        idle(1);

        // Both requesting single beats from a fresh pointer.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 64'h100 + i, 1, 1, 64'h200 + i, 0, 0, 0);
        drain();

        // P1 three-beat burst with P0 requesting throughout.
        step(1, 0, 0, 0, 0, 1, 0, 64'hB1, 0, 0, 0);
        step(1, 0, 1, 1, 64'hA0, 1, 0, 64'hB2, 0, 0, 0);
        step(1, 0, 1, 1, 64'hA0, 1, 1, 64'hB3, 0, 0, 0);
        step(1, 0, 1, 1, 64'hA0, 0, 0, 0, 0, 0, 0);
        drain();

        // Fill the order queue, overflow attempt, then push+pop together.
        for (int i = 0; i < 17; i++) step(1, 0, 1, 1, 64'h300 + i, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 64'h3FF, 0, 0, 0, 0, 1, 32'hC0);
        step(1, 0, 1, 1, 64'h400, 1, 1, 64'h401, 0, 1, 32'hC1);
        step(1, 0, 1, 1, 64'h402, 0, 0, 0, 0, 0, 0);
        drain();

        // Memory busy for two cycles in the middle of a P0 burst.
        step(1, 0, 1, 0, 64'h501, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 64'h502, 1, 1, 64'h5FF, 1, 0, 0);
        step(1, 0, 1, 0, 64'h502, 1, 1, 64'h5FF, 1, 0, 0);
        step(1, 0, 1, 0, 64'h502, 1, 1, 64'h5FF, 0, 0, 0);
        step(1, 0, 1, 1, 64'h503, 1, 1, 64'h5FF, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 64'h5FF, 0, 0, 0);
        drain();

        // Stray response, then flush clears the error.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
        idle(1);
        step(1, 0, 1, 0, 64'h601, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 64'h602, 1, 1, 64'h6FF, 0, 1, 32'h1);
        idle(1);

        // Reset in the middle of a burst, then a response that has no owner.
        step(1, 0, 1, 0, 64'h701, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 64'h702, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 64'h7FF, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 499) != 0);
            rm = ($urandom_range(0, 299) == 0);
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            l0 = ($urandom_range(0, 2) == 0);
            l1 = ($urandom_range(0, 2) == 0);
            mb = ($urandom_range(0, 5) == 0);
            mv = (ids_m.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 30) == 0);
            step(rn, rm, r0, l0, {$urandom, $urandom}, r1, l1, {$urandom, $urandom}, mb, mv, $urandom);
        end

        repeat (2) @(posedge clk);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
